// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

    localparam int SERIAL_ADD_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/fa_bit.sv
// Single full-adder cell, reused for every bit position of the serial add.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: {cout,sum} = op_a + op_b + cin, LSB first, one fa_bit cell.
// Optional ovf output (two's-complement overflow) enabled by SERIAL_ADD_OVF_EN.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SERIAL_ADD_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e          state;
    state_e          state_next;
    logic            accept;
    logic            last_bit;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_co;

    fa_bit u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Counter holds at WIDTH-1 on the final bit so it never wraps (WIDTH a power of two).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= 1'b0;
`endif
        end else if (accept) begin
            a_sh  <= op_a;
            b_sh  <= op_b;
            carry <= cin;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= 1'b0;
`endif
        end else if (state == RUN) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            carry <= fa_co;
            sum   <= {fa_s, sum[WIDTH-1:1]};
            if (last_bit) begin
                cout <= fa_co;
`ifdef SERIAL_ADD_OVF_EN
                ovf  <= carry ^ fa_co;
`endif
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized self-checking bench for serial_add_ctrl (WIDTH=8) against an arithmetic model.
`timescale 1ns/1ps
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op_a  (op_a),
        .op_b  (op_b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] model_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic c);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    function automatic logic model_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic c);
        logic [W:0] r;
        r = model_add(a, b, c);
        return (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    endfunction

    function automatic logic get_ovf();
`ifdef SERIAL_ADD_OVF_EN
        return ovf;
`else
        return 1'b0;
`endif
    endfunction

    // Pulses start with the given operands, scrambles inputs during RUN, and returns
    // cycles from the start cycle to the done cycle (-1 on timeout) plus the result.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          output int lat, output logic [W-1:0] s, output logic co,
                          output logic ov);
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        cin   = c;
        start = 1'b1;
        lat   = -1;
        s     = '0;
        co    = 1'b0;
        ov    = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            start = 1'b0;
            op_a  = W'($urandom);
            op_b  = W'($urandom);
            cin   = 1'($urandom);
            if (done) begin
                lat = i;
                s   = sum;
                co  = cout;
                ov  = get_ovf();
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        op_a  = 8'hAA;
        op_b  = 8'h55;
        cin   = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++;
        if (sum !== 8'h00) begin errors++; $display("FAIL reset_sum got %h want 00", sum); end
        checks++;
        if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b want 0", cout); end
`ifdef SERIAL_ADD_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
`endif
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [W-1:0] va[3];
        logic [W-1:0] vb[3];
        logic         vc[3];
        logic [W:0]   exp;
        int           lat;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        va = '{8'h0F, 8'hFF, 8'hFF};
        vb = '{8'h01, 8'h01, 8'hFF};
        vc = '{1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) begin
            run_op(va[k], vb[k], vc[k], lat, s, co, ov);
            exp = model_add(va[k], vb[k], vc[k]);
            checks++;
            if (lat != W + 1) begin errors++; $display("FAIL dir_latency[%0d] got %0d want %0d", k, lat, W + 1); end
            checks++;
            if (s !== exp[W-1:0]) begin errors++; $display("FAIL dir_sum[%0d] got %h want %h", k, s, exp[W-1:0]); end
            checks++;
            if (co !== exp[W]) begin errors++; $display("FAIL dir_cout[%0d] got %b want %b", k, co, exp[W]); end
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin errors++; $display("FAIL dir_done_width[%0d] got %b want 0", k, done); end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic [W:0]   exp;
        int           lat;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        for (int k = 0; k < 20; k++) begin
            a = W'($urandom);
            b = W'($urandom);
            c = 1'($urandom);
            run_op(a, b, c, lat, s, co, ov);
            exp = model_add(a, b, c);
            checks++;
            if (lat != W + 1) begin errors++; $display("FAIL rnd_latency[%0d] got %0d want %0d", k, lat, W + 1); end
            checks++;
            if ({co, s} !== exp) begin errors++; $display("FAIL rnd_result[%0d] a=%h b=%h c=%b got %h want %h", k, a, b, c, {co, s}, exp); end
`ifdef SERIAL_ADD_OVF_EN
            checks++;
            if (ov !== model_ovf(a, b, c)) begin errors++; $display("FAIL rnd_ovf[%0d] got %b want %b", k, ov, model_ovf(a, b, c)); end
`endif
            repeat (2) @(negedge clk);
            checks++;
            if ({cout, sum} !== exp || busy !== 1'b0) begin
                errors++;
                $display("FAIL rnd_hold[%0d] got %h busy=%b want %h busy=0", k, {cout, sum}, busy, exp);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [W:0]   exp;
        int           ndone;
        int           t1;
        logic [W:0]   r1;
        exp = model_add(8'h3C, 8'h5A, 1'b1);
        ndone = 0;
        t1 = -1;
        r1 = '0;
        @(negedge clk);
        op_a  = 8'h3C;
        op_b  = 8'h5A;
        cin   = 1'b1;
        start = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            start = (i == 3);
            if (i == 3) begin
                op_a = 8'hC3;
                op_b = 8'h11;
                cin  = 1'b0;
            end
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    t1 = i;
                    r1 = {cout, sum};
                end
            end
        end
        checks++;
        if (ndone != 1) begin errors++; $display("FAIL ign_done_count got %0d want 1", ndone); end
        checks++;
        if (t1 != W + 1) begin errors++; $display("FAIL ign_latency got %0d want %0d", t1, W + 1); end
        checks++;
        if (r1 !== exp) begin errors++; $display("FAIL ign_result got %h want %h", r1, exp); end
    endtask

    task automatic test_back_to_back();
        logic [W:0] exp1;
        logic [W:0] exp2;
        logic [W:0] r1;
        logic [W:0] r2;
        int         ndone;
        int         t1;
        int         t2;
        exp1 = model_add(8'h81, 8'h92, 1'b0);
        exp2 = model_add(8'h27, 8'hE4, 1'b1);
        ndone = 0;
        t1 = -1;
        t2 = -1;
        r1 = '0;
        r2 = '0;
        @(negedge clk);
        op_a  = 8'h81;
        op_b  = 8'h92;
        cin   = 1'b0;
        start = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 1) begin
                op_a = 8'h27;
                op_b = 8'hE4;
                cin  = 1'b1;
            end
            if (ndone == 1 && i == t1 + 1) begin
                start = 1'b0;
                checks++;
                if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_after_done got %b want 1", busy); end
            end
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    t1 = i;
                    r1 = {cout, sum};
                end else if (ndone == 2) begin
                    t2 = i;
                    r2 = {cout, sum};
                end
            end
        end
        start = 1'b0;
        checks++;
        if (ndone != 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", ndone); end
        checks++;
        if (t1 != W + 1 || t2 - t1 != W + 1) begin
            errors++;
            $display("FAIL b2b_spacing got t1=%0d gap=%0d want t1=%0d gap=%0d", t1, t2 - t1, W + 1, W + 1);
        end
        checks++;
        if (r1 !== exp1) begin errors++; $display("FAIL b2b_result1 got %h want %h", r1, exp1); end
        checks++;
        if (r2 !== exp2) begin errors++; $display("FAIL b2b_result2 got %h want %h", r2, exp2); end
    endtask

    task automatic test_reset_mid_run();
        int           ndone;
        logic [W:0]   exp;
        int           lat;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        ndone = 0;
        @(negedge clk);
        op_a  = 8'hF0;
        op_b  = 8'h0F;
        cin   = 1'b1;
        start = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || sum !== 8'h00 || done !== 1'b0 || cout !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state got busy=%b done=%b sum=%h cout=%b want all 0", busy, done, sum, cout);
        end
        rst_n = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        checks++;
        if (ndone != 0) begin errors++; $display("FAIL midrst_no_done got %0d want 0", ndone); end
        exp = model_add(8'h6D, 8'hB9, 1'b0);
        run_op(8'h6D, 8'hB9, 1'b0, lat, s, co, ov);
        checks++;
        if (lat != W + 1 || {co, s} !== exp) begin
            errors++;
            $display("FAIL midrst_restart got lat=%0d res=%h want lat=%0d res=%h", lat, {co, s}, W + 1, exp);
        end
    endtask

`ifdef SERIAL_ADD_OVF_EN
    task automatic test_ovf();
        int           lat;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        run_op(8'h7F, 8'h01, 1'b0, lat, s, co, ov);
        checks++;
        if (ov !== 1'b1 || s !== 8'h80) begin errors++; $display("FAIL ovf_pos got ovf=%b sum=%h want ovf=1 sum=80", ov, s); end
        run_op(8'hFF, 8'h01, 1'b0, lat, s, co, ov);
        checks++;
        if (ov !== 1'b0 || s !== 8'h00) begin errors++; $display("FAIL ovf_none got ovf=%b sum=%h want ovf=0 sum=00", ov, s); end
    endtask
`endif

    initial begin
        start = 1'b0;
        rst_n = 1'b0;
        op_a  = '0;
        op_b  = '0;
        cin   = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
`ifdef SERIAL_ADD_OVF_EN
        test_ovf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
